// File: rtl/token_sink_pkg.sv
// Shared types for the token_sink slice: the sink-side flow-control FSM encoding.
// Imported by token_sink; package name pkg_en is what the rest of the codebase expects.
package pkg_en;

    typedef enum logic [1:0] {
        sEMPTY   = 2'd0,
        sACTIVE  = 2'd1,
        sBACKOFF = 2'd2
    } fsm_sink;

endpackage

// File: rtl/token_sink_ring.sv
// RingBuffCTRL: write/read pointers and occupancy for a power-of-two ring buffer.
// The caller qualifies I_We/I_Re, so no overflow/underflow guarding is done here.
module RingBuffCTRL #(
    parameter int NUM_ENTRY = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         I_We,
    input  logic                         I_Re,
    output logic [$clog2(NUM_ENTRY)-1:0] O_WAddr,
    output logic [$clog2(NUM_ENTRY)-1:0] O_RAddr,
    output logic [$clog2(NUM_ENTRY):0]   O_Num
);

    localparam int AW = $clog2(NUM_ENTRY);
    localparam int NW = AW + 1;

    // Pointers wrap for free because NUM_ENTRY is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            O_WAddr <= '0;
            O_RAddr <= '0;
            O_Num   <= '0;
        end else begin
            if (I_We) O_WAddr <= O_WAddr + AW'(1);
            if (I_Re) O_RAddr <= O_RAddr + AW'(1);
            O_Num <= O_Num + NW'(I_We) - NW'(I_Re);
        end
    end

endmodule

// File: rtl/token_sink.sv
// token_sink: Valid/Nack token buffer with registered back-pressure and hysteresis.
// Optional sticky drop detection on O_Ovf is enabled by defining TOKEN_SINK_OVF_DETECT_EN.
module token_sink
    import pkg_en::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int SLACK    = 2,
    parameter int NACK_LOW = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Valid,
    input  logic [WIDTH-1:0]         I_Data,
    output logic                     O_Nack,
    output logic                     O_Valid,
    output logic [WIDTH-1:0]         O_Data,
    input  logic                     I_Nack,
    output logic [$clog2(DEPTH):0]   O_Num,
    output logic                     O_Ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] FULL_NUM = NW'(DEPTH);
    localparam logic [NW-1:0] HI_MARK  = NW'(DEPTH - SLACK);
    localparam logic [NW-1:0] LO_MARK  = NW'(NACK_LOW);

    logic              push;
    logic              pop;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [NW-1:0]     num;
    logic [NW-1:0]     num_next;
    logic              nack_d;
    fsm_sink           state;
    fsm_sink           state_next;
    logic [WIDTH-1:0]  mem [DEPTH];

    // A full buffer still accepts a token when the head leaves in the same cycle.
    assign O_Valid  = (num != '0);
    assign pop      = O_Valid & ~I_Nack;
    assign push     = I_Valid & ((num < FULL_NUM) | pop);
    assign num_next = num + NW'(push) - NW'(pop);
    assign O_Num    = num;
    assign O_Data   = mem[raddr];

    RingBuffCTRL #(
        .NUM_ENTRY (DEPTH)
    ) u_ring (
        .clock   (clock),
        .reset   (reset),
        .I_We    (push),
        .I_Re    (pop),
        .O_WAddr (waddr),
        .O_RAddr (raddr),
        .O_Num   (num)
    );

    always_ff @(posedge clock) begin
        if (push) mem[waddr] <= I_Data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= sEMPTY;
            O_Nack <= 1'b0;
        end else begin
            state  <= state_next;
            O_Nack <= nack_d;
        end
    end

    // Back-off engages at DEPTH-SLACK so in-flight tokens still fit, and releases only at NACK_LOW.
    always_comb begin
        state_next = state;
        case (state)
            sEMPTY, sACTIVE: begin
                if (num_next >= HI_MARK)  state_next = sBACKOFF;
                else if (num_next != '0)  state_next = sACTIVE;
                else                      state_next = sEMPTY;
            end
            sBACKOFF: begin
                if (num_next > LO_MARK)   state_next = sBACKOFF;
                else if (num_next != '0)  state_next = sACTIVE;
                else                      state_next = sEMPTY;
            end
            default: state_next = sEMPTY;
        endcase
    end

    always_comb begin
        nack_d = (state_next == sBACKOFF);
    end

`ifdef TOKEN_SINK_OVF_DETECT_EN
    logic ovf;

    // Any valid token that is not pushed was dropped at a full buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                ovf <= 1'b0;
        else if (I_Valid && !push) ovf <= 1'b1;
    end

    assign O_Ovf = ovf;
`else
    assign O_Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_token_sink.sv
// Scoreboard bench for token_sink at default parameters; accepted tokens are queued and
// checked in order by a monitor whenever the DUT pops. Honours TOKEN_SINK_OVF_DETECT_EN.
module tb_token_sink;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef TOKEN_SINK_OVF_DETECT_EN
    localparam logic [31:0] EXP_OVF = 32'd1;
`else
    localparam logic [31:0] EXP_OVF = 32'd0;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   I_Valid = 1'b0;
    logic [WIDTH-1:0]       I_Data = '0;
    logic                   I_Nack = 1'b1;
    logic                   O_Nack;
    logic                   O_Valid;
    logic [WIDTH-1:0]       O_Data;
    logic [$clog2(DEPTH):0] O_Num;
    logic                   O_Ovf;

    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    token_sink #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .SLACK    (2),
        .NACK_LOW (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Valid (I_Valid),
        .I_Data  (I_Data),
        .O_Nack  (O_Nack),
        .O_Valid (O_Valid),
        .O_Data  (O_Data),
        .I_Nack  (I_Nack),
        .O_Num   (O_Num),
        .O_Ovf   (O_Ovf)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs, let the rising edge pass, return 1 ns after it.
    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic n,
                                  input logic accept);
        I_Valid = v;
        I_Data  = d;
        I_Nack  = n;
        if (accept) exp_q.push_back(d);
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int num, input logic valid,
                               input logic nack);
        check_output({tag, "_num"},   32'(O_Num),   32'(num));
        check_output({tag, "_valid"}, 32'(O_Valid), 32'(valid));
        check_output({tag, "_nack"},  32'(O_Nack),  32'(nack));
    endtask

    // Monitor: a pop happens on the coming edge, so the head must match the oldest queued token.
    always @(negedge clock) begin
        if (reset && O_Valid && !I_Nack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_unexpected actual=%0h required=none", O_Data);
            end else begin
                check_output("pop_data", O_Data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 0, 1'b0, 1'b0);
        check_output("reset_ovf", 32'(O_Ovf), 32'd0);
        reset = 1'b1;

        // Three pushes while stalled: Nack rises after the second token
        apply_stimulus(1'b1, 32'hA, 1'b1, 1'b1);
        check_state("push_a", 1, 1'b1, 1'b0);
        check_output("push_a_data", O_Data, 32'hA);
        apply_stimulus(1'b1, 32'hB, 1'b1, 1'b1);
        check_state("push_b", 2, 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'hC, 1'b1, 1'b1);
        check_state("push_c", 3, 1'b1, 1'b1);
        check_output("hold_a_data", O_Data, 32'hA);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("hold_a_data2", O_Data, 32'hA);

        // Fill, then stream at full: one pop and one push per cycle
        apply_stimulus(1'b1, 32'hD, 1'b1, 1'b1);
        check_state("full", 4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1);
            check_output("stream_num", 32'(O_Num), 32'd4);
            check_output("stream_ovf", 32'(O_Ovf), 32'd0);
        end
        check_output("stream_head", O_Data, 32'hD);

        // Drop at full with the consumer stalled
        apply_stimulus(1'b1, 32'hDEAD, 1'b1, 1'b0);
        check_output("drop_num", 32'(O_Num), 32'd4);
        check_output("drop_ovf", 32'(O_Ovf), EXP_OVF);
        check_output("drop_head", O_Data, 32'hD);

        // Hysteresis release while draining
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_state("drain3", 3, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_state("drain2", 2, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_state("drain1", 1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        check_state("drain0", 0, 1'b0, 1'b0);

        // Nine tokens with intermittent pops: pointers wrap twice
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 32'h100 + 32'(i), ((i % 2) == 0) && (i < 8), 1'b1);
        end
        check_output("wrap_num", 32'(O_Num), 32'd4);
        for (int i = 3; i >= 0; i--) begin
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
            check_output("wrap_drain_num", 32'(O_Num), 32'(i));
        end

        // Asynchronous reset mid-transfer
        apply_stimulus(1'b1, 32'h21, 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'h22, 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'h23, 1'b1, 1'b1);
        check_state("pre_reset", 3, 1'b1, 1'b1);
        I_Valid = 1'b0;
        reset   = 1'b0;
        #1;
        check_state("async_reset", 0, 1'b0, 1'b0);
        check_output("async_reset_ovf", 32'(O_Ovf), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        apply_stimulus(1'b1, 32'h5, 1'b1, 1'b1);
        check_state("post_reset", 1, 1'b1, 1'b0);
        check_output("post_reset_data", O_Data, 32'h5);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        I_Nack = 1'b1;
        check_output("final_num", 32'(O_Num), 32'd0);
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
